msk_hpc3_rnd_src: RTL

MSK_HPC3_RND_SRC -- requirements
Module: msk_hpc3_rnd_src

---
 rtl/msk_hpc3_rnd_src.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/msk_hpc3_rnd_src.sv
// msk_hpc3_rnd_src
// Supplies the fresh randomness for one HPC3 G(4) masked multiplication.
// NL 32-bit xorshift32 lanes are seeded one word at a time. The lanes are
// stepped once (warm-up) and are then offered as a valid/ready stream.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   seed_data   seed word for the lane selected by the internal index
//   seed_valid  seed_data is offered
//   seed_ready  block accepts a seed word (EMPTY / SEEDING)
//   reseed      single-cycle request to restart seeding
//   rnd         RW bits of randomness, lane 0 in the LSBs
//   rnd_valid   rnd holds a word that has not been consumed
//   rnd_ready   consumer takes rnd this cycle
//   words       saturating count of delivered words

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_hpc3_rnd_src #(
    parameter int d = `DEFAULTSHARES,
    localparam int RW = 2 * d * (d - 1),
    localparam int NL = (RW + 31) / 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   seed_data,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic          reseed,
    output logic [RW-1:0] rnd,
    output logic          rnd_valid,
    input  logic          rnd_ready,
    output logic [15:0]   words
);

    localparam int IW = (NL > 1) ? $clog2(NL) : 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        SEEDING = 2'd1,
        WARM    = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [IW-1:0]      idx_r;
    logic [IW-1:0]      idx_next_s;
    logic [NL*32-1:0]   lanes_r;
    logic [NL*32-1:0]   lanes_next_s;
    logic [15:0]        words_r;
    logic               seed_ready_r;
    logic               rnd_valid_r;
    logic               reseed_s;
    logic               beat_s;
    logic               hs_s;
    logic               step_s;

    // One xorshift32 step of a single lane.
    function automatic logic [31:0] xorshift32(input logic [31:0] x_in);
        logic [31:0] x;
        x = x_in;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Handshake qualification; reseed outranks a coincident seed beat and is void in EMPTY.
    always_comb begin
        reseed_s = reseed & (state_r != EMPTY);
        beat_s   = seed_valid & seed_ready_r & ~reseed_s;
        hs_s     = rnd_valid_r & rnd_ready;
        step_s   = ((state_r == WARM) & ~reseed_s) | hs_s;
    end

    // Next-state and lane-index logic.
    always_comb begin
        next_s     = state_r;
        idx_next_s = idx_r;
        case (state_r)
            EMPTY: begin
                if (beat_s) begin
                    next_s = (NL == 1) ? WARM : SEEDING;
                end else begin
                    next_s = EMPTY;
                end
            end
            SEEDING: begin
                if (reseed_s) begin
                    next_s = SEEDING;
                end else if (beat_s && (idx_r == IW'(NL - 1))) begin
                    next_s = WARM;
                end else begin
                    next_s = SEEDING;
                end
            end
            WARM: begin
                if (reseed_s) begin
                    next_s = SEEDING;
                end else begin
                    next_s = RUN;
                end
            end
            RUN: begin
                if (reseed_s) begin
                    next_s = SEEDING;
                end else begin
                    next_s = RUN;
                end
            end
            default: begin
                next_s = EMPTY;
            end
        endcase
        // The last beat wraps the index so WARM/RUN always see idx = 0.
        if (reseed_s) begin
            idx_next_s = {IW{1'b0}};
        end else if (beat_s) begin
            if (idx_r == IW'(NL - 1)) begin
                idx_next_s = {IW{1'b0}};
            end else begin
                idx_next_s = idx_r + IW'(1);
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Next lane contents: load the indexed lane on a beat, step all lanes on warm-up/handshake.
    always_comb begin
        lanes_next_s = lanes_r;
        for (int i = 0; i < NL; i++) begin
            if (beat_s && (idx_r == IW'(i))) begin
                lanes_next_s[i*32 +: 32] = (seed_data == 32'h0000_0000) ? 32'h0000_0001 : seed_data;
            end else if (step_s) begin
                lanes_next_s[i*32 +: 32] = xorshift32(lanes_r[i*32 +: 32]);
            end else begin
                lanes_next_s[i*32 +: 32] = lanes_r[i*32 +: 32];
            end
        end
    end

    // State, index, lanes, counter and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= EMPTY;
            idx_r        <= {IW{1'b0}};
            lanes_r      <= {(NL*32){1'b0}};
            words_r      <= 16'h0000;
            seed_ready_r <= 1'b1;
            rnd_valid_r  <= 1'b0;
        end else begin
            state_r      <= next_s;
            idx_r        <= idx_next_s;
            lanes_r      <= lanes_next_s;
            seed_ready_r <= (next_s == EMPTY) || (next_s == SEEDING);
            rnd_valid_r  <= (next_s == RUN);
            if (hs_s && (words_r != 16'hFFFF)) begin
                words_r <= words_r + 16'h0001;
            end else begin
                words_r <= words_r;
            end
        end
    end

    assign rnd        = lanes_r[RW-1:0];
    assign rnd_valid  = rnd_valid_r;
    assign seed_ready = seed_ready_r;
    assign words      = words_r;

endmodule
